ring_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource among N requesters.
//   A one-hot ring pointer rotates like the 4-bit ring counter and marks the

---
 rtl/ring_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer and a registered, held grant.
// Define TIMEOUT_EN to enable the hold counter and MAX_HOLD preemption.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic           Clk,
    input  logic           Ori,
    input  logic [N-1:0]   Req,
    output logic [N-1:0]   Gnt,
    output logic [IDW-1:0] GntId,
    output logic           Busy,
    output logic [N-1:0]   Ptr,
    output logic           Preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0] ptr_idx;
    logic [IDW:0]   win;
    logic [IDW:0]   hand;
    logic           own_req;
    logic           others;
    logic           handover;

`ifdef TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       pre_q, pre_d;
    logic       timeout;
`else
    logic unused_hold;
    assign unused_hold = (MAX_HOLD != 0);
`endif

    // Circular first-set scan beginning at index start; MSB flags a winner.
    function automatic logic [IDW:0] arb(input logic [N-1:0] r, input int start);
        logic [IDW:0] res;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = (start + i) % N;
            if (((r >> j) & N'(1)) != '0) res = {1'b1, IDW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) ptr_idx = IDW'(i);
        end
    end

    assign own_req = |(Req & gnt_q);
    assign others  = |(Req & ~gnt_q);
    assign win     = arb(Req, int'(ptr_idx));
    // Handover scan starts just past the owner and never considers it.
    assign hand    = arb(Req & ~gnt_q, (int'(id_q) + 1) % N);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        handover = 1'b0;
`ifdef TIMEOUT_EN
        cnt_d    = cnt_q;
        pre_d    = 1'b0;
        timeout  = (cnt_q == HOLD_LAST) && own_req && others;
`endif
        unique case (state_q)
            IDLE: begin
                if (win[IDW]) begin
                    state_d = GRANT;
                    gnt_d   = N'(1) << win[IDW-1:0];
                    id_d    = win[IDW-1:0];
`ifdef TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                handover = !own_req;
`ifdef TIMEOUT_EN
                handover = handover || timeout;
`endif
                if (handover) begin
                    ptr_d = {gnt_q[N-2:0], gnt_q[N-1]};
`ifdef TIMEOUT_EN
                    pre_d = timeout;
                    cnt_d = '0;
`endif
                    if (hand[IDW]) begin
                        gnt_d = N'(1) << hand[IDW-1:0];
                        id_d  = hand[IDW-1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                    end
                end
`ifdef TIMEOUT_EN
                else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Ori) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= N'(1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Ori) begin
            cnt_q <= '0;
            pre_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end
    assign Preempt = pre_q;
`else
    assign Preempt = 1'b0;
`endif

    assign Gnt   = gnt_q;
    assign GntId = id_q;
    assign Busy  = (state_q == GRANT);
    assign Ptr   = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios plus random
// traffic compared every cycle against an index-based behavioural model.
module tb_ring_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef TIMEOUT_EN
    localparam int MH  = 4;
    localparam bit TO  = 1'b1;
`else
    localparam int MH  = 8;
    localparam bit TO  = 1'b0;
`endif

    logic           clk;
    logic           ori;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic [N-1:0]   ptr;
    logic           preempt;

    int tests;
    int failed;

    // Model state: owner index (-1 = nobody), pointer index, hold count.
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_pre;

    ring_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MH)) dut (
        .Clk    (clk),
        .Ori    (ori),
        .Req    (req),
        .Gnt    (gnt),
        .GntId  (gnt_id),
        .Busy   (busy),
        .Ptr    (ptr),
        .Preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int scan(input logic [N-1:0] r, input int start, input int excl);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (start + i) % N;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        int w;
        bit rel;
        bit tmo;
        bit oth;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
            m_pre   = 0;
            return;
        end
        m_pre = 0;
        if (m_owner < 0) begin
            w = scan(r, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 0;
            end
        end else begin
            oth = 1'b0;
            for (int i = 0; i < N; i++)
                if (i != m_owner && r[i]) oth = 1'b1;
            rel = !r[m_owner];
            tmo = TO && (m_cnt == MH - 1) && r[m_owner] && oth;
            if (rel || tmo) begin
                m_ptr   = (m_owner + 1) % N;
                m_pre   = tmo ? 1 : 0;
                w       = scan(r, m_ptr, m_owner);
                m_owner = w;
                m_cnt   = 0;
            end else if (m_cnt < MH - 1) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("gnt",     int'(gnt),     (m_owner < 0) ? 0 : (1 << m_owner));
        chk("gnt_id",  int'(gnt_id),  (m_owner < 0) ? 0 : m_owner);
        chk("busy",    int'(busy),    (m_owner < 0) ? 0 : 1);
        chk("ptr",     int'(ptr),     1 << m_ptr);
        chk("preempt", int'(preempt), m_pre);
        chk("onehot",  int'($countones(gnt) <= 1), 1);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic rs);
        req = r;
        ori = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        compare_all();
    endtask

    initial begin
        int exp_seq [4];
        logic [N-1:0] r;
        int cur;
        tests   = 0;
        failed  = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_pre   = 0;
        req     = '0;
        ori     = 1'b1;
        @(negedge clk);

        // Reset with all requests asserted.
        repeat (2) begin
            cyc(4'b1111, 1'b1);
            chk("rst_gnt",  int'(gnt),  0);
            chk("rst_ptr",  int'(ptr),  1);
            chk("rst_busy", int'(busy), 0);
        end

        // Single requester, hold, release.
        cyc(4'b0100, 1'b0);
        chk("t2_gnt", int'(gnt),    4);
        chk("t2_id",  int'(gnt_id), 2);
        chk("t2_bsy", int'(busy),   1);
        repeat (5) cyc(4'b0100, 1'b0);
        chk("t2_hold", int'(gnt), 4);
        cyc(4'b0000, 1'b0);
        chk("t2_rel_gnt", int'(gnt),  0);
        chk("t2_rel_ptr", int'(ptr),  8);
        chk("t2_rel_bsy", int'(busy), 0);

        // Rotation 0,1,2,3,0 with back-to-back handover.
        cyc(4'b0000, 1'b1);
        cyc(4'b1111, 1'b0);
        chk("t3_first", int'(gnt), 1);
        exp_seq = '{2, 4, 8, 1};
        cur = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(4'b1111, 1'b0);
            r = 4'b1111;
            r[cur] = 1'b0;
            cyc(r, 1'b0);
            chk("t3_order", int'(gnt), exp_seq[k]);
            chk("t3_nogap", int'(busy), 1);
            cur = (cur + 1) % N;
        end

        // Wrap from owner 3 back to 0.
        cyc(4'b0000, 1'b1);
        cyc(4'b1000, 1'b0);
        chk("t4_own3", int'(gnt), 8);
        cyc(4'b0011, 1'b0);
        chk("t4_gnt", int'(gnt), 1);
        chk("t4_ptr", int'(ptr), 1);

        // Reset in the middle of a grant.
        cyc(4'b0000, 1'b1);
        cyc(4'b0010, 1'b0);
        cyc(4'b0010, 1'b0);
        chk("t5_pre", int'(gnt), 2);
        cyc(4'b0010, 1'b1);
        chk("t5_gnt", int'(gnt),     0);
        chk("t5_id",  int'(gnt_id),  0);
        chk("t5_bsy", int'(busy),    0);
        chk("t5_ptr", int'(ptr),     1);
        chk("t5_pe",  int'(preempt), 0);

`ifdef TIMEOUT_EN
        // Timeout preemption with a competing requester.
        cyc(4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0011, 1'b0);
            chk("t6_hold", int'(gnt), 1);
            chk("t6_nope", int'(preempt), 0);
        end
        cyc(4'b0011, 1'b0);
        chk("t6_gnt", int'(gnt),     2);
        chk("t6_pe",  int'(preempt), 1);
        cyc(4'b0011, 1'b0);
        chk("t6_pulse", int'(preempt), 0);
        // Lone requester keeps the grant.
        cyc(4'b0000, 1'b1);
        repeat (12) begin
            cyc(4'b0001, 1'b0);
            chk("t6_lone", int'(gnt), 1);
        end
`endif

        // Random traffic against the model.
        r = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            cyc(r, ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
